// File: rtl/ccg_bist_driver_if.sv
// rtl/ccg_bist_driver_if.sv - BIST driver control/stimulus/response bundle
// master drives run control and circuit response; slave is the BIST driver.
interface ccg_bist_driver_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_patterns;
  logic [19:0]      seed;
  logic [11:0]      golden_sig;
  logic [11:0]      resp_in;
  logic [19:0]      pat_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [11:0]      signature;
  logic [CNT_W-1:0] pat_count;

  modport master (
    output start, num_patterns, seed, golden_sig, resp_in,
    input  pat_out, busy, done, pass, signature, pat_count
  );

  modport slave (
    input  start, num_patterns, seed, golden_sig, resp_in,
    output pat_out, busy, done, pass, signature, pat_count
  );
endinterface

// File: rtl/ccg_bist_driver.sv
// rtl/ccg_bist_driver.sv - LFSR stimulus / MISR compaction BIST driver
// Each pattern takes an APPLY (settle) cycle and a CAPTURE cycle.
module ccg_bist_driver #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ccg_bist_driver_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_APPLY   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [19:0]      r_pat;
  logic [19:0]      w_pat_next;
  logic [11:0]      r_sig;
  logic [11:0]      w_sig_next;
  logic             r_pass;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_capture;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_pat_next = {r_pat[18:0], r_pat[19] ^ r_pat[16]};
  // Galois MISR: shift, fold the dropped MSB back onto taps 0/1/4/6, absorb response
  assign w_sig_next = {r_sig[10:0], 1'b0} ^ bus.resp_in ^ ({12{r_sig[11]}} & 12'h053);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = (bus.num_patterns == '0) ? S_DONE : S_APPLY;
        end
      end
      S_APPLY:   w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = (w_cnt_inc == r_num) ? S_DONE : S_APPLY;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b1;
    w_done    = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy   = 1'b0;
        w_accept = bus.start;
      end
      S_CAPTURE: w_capture = 1'b1;
      S_DONE:    w_done    = 1'b1;
      default:   w_busy    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= '0;
      r_cnt  <= '0;
      r_pat  <= '0;
      r_sig  <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_num  <= bus.num_patterns;
      r_cnt  <= '0;
      // all-zero is the LFSR lock-up state, so substitute a non-zero seed
      r_pat  <= (bus.seed == 20'h0) ? 20'h00001 : bus.seed;
      r_sig  <= '0;
      r_pass <= 1'b0;
    end else if (w_capture) begin
      r_cnt  <= w_cnt_inc;
      r_pat  <= w_pat_next;
      r_sig  <= w_sig_next;
    end else if (w_done) begin
      r_pass <= (r_sig == bus.golden_sig);
    end
  end

  assign bus.pat_out   = r_pat;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.pass      = r_pass;
  assign bus.signature = r_sig;
  assign bus.pat_count = r_cnt;

endmodule

// File: tb/tb_ccg_bist_driver.sv
// tb/tb_ccg_bist_driver.sv - randomized self-checking bench for ccg_bist_driver
// Reference model works on pattern schedule (2 cycles per pattern) and polynomial arithmetic.
module tb_ccg_bist_driver;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ccg_bist_driver_if #(.CNT_W(CW)) b ();

  ccg_bist_driver #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] lfsr_ref(input logic [19:0] p);
    int v;
    int tap;
    v   = int'(p);
    tap = ((v >> 19) ^ (v >> 16)) & 1;
    return 20'(((v << 1) | tap) & 32'hFFFFF);
  endfunction

  // Polynomial x^12+x^6+x^4+x+1 -> reduction constant 0x053 after dividing out x^12
  function automatic logic [11:0] misr_ref(input logic [11:0] s, input logic [11:0] r);
    int v;
    v = int'(s) * 2;
    if (v >= 4096) v = (v - 4096) ^ 32'h053;
    return 12'(v ^ int'(r));
  endfunction

  task automatic run_model(input logic [19:0] sd, input logic [CW-1:0] n, input bit noisy);
    logic [19:0] mp;
    logic [11:0] ms;
    logic [11:0] r;
    logic [11:0] g;
    @(negedge clk);
    b.start = 1'b1; b.seed = sd; b.num_patterns = n; b.resp_in = 12'($urandom);
    mp = (sd == 20'h0) ? 20'h00001 : sd;
    ms = '0;
    @(negedge clk);
    b.start = (noisy && n != 0) ? 1'($urandom) : 1'b0;
    if (noisy) begin
      b.seed = 20'($urandom); b.num_patterns = CW'($urandom); b.golden_sig = 12'($urandom);
    end
    checks++;
    if (b.pat_out !== mp || b.signature !== 12'h0 || b.pat_count !== '0 || b.busy !== 1'b1 ||
        b.done !== (n == 0) || b.pass !== 1'b0) begin
      errors++;
      $display("FAIL run_start: pat=%h sig=%h cnt=%0d busy=%b done=%b pass=%b exp pat=%h n=%0d",
               b.pat_out, b.signature, b.pat_count, b.busy, b.done, b.pass, mp, n);
    end
    for (int k = 0; k < int'(n); k++) begin
      @(negedge clk);
      r = 12'($urandom);
      b.resp_in = r;
      if (noisy) begin
        b.start = 1'($urandom); b.golden_sig = 12'($urandom);
      end
      checks++;
      if (b.pat_out !== mp || b.signature !== ms || b.pat_count !== CW'(k) ||
          b.busy !== 1'b1 || b.done !== 1'b0) begin
        errors++;
        $display("FAIL apply_hold k=%0d: pat=%h sig=%h cnt=%0d done=%b exp pat=%h sig=%h cnt=%0d",
                 k, b.pat_out, b.signature, b.pat_count, b.done, mp, ms, k);
      end
      @(negedge clk);
      ms = misr_ref(ms, r);
      mp = lfsr_ref(mp);
      b.start   = (noisy && k + 1 < int'(n)) ? 1'($urandom) : 1'b0;
      b.resp_in = 12'($urandom);
      checks++;
      if (b.pat_out !== mp || b.signature !== ms || b.pat_count !== CW'(k + 1) ||
          b.busy !== 1'b1 || b.done !== (k + 1 == int'(n))) begin
        errors++;
        $display("FAIL capture k=%0d: pat=%h sig=%h cnt=%0d done=%b exp pat=%h sig=%h cnt=%0d",
                 k, b.pat_out, b.signature, b.pat_count, b.done, mp, ms, k + 1);
      end
    end
    g = ($urandom_range(0, 1) == 1) ? ms : 12'($urandom);
    b.golden_sig = g;
    @(negedge clk);
    checks++;
    if (b.busy !== 1'b0 || b.done !== 1'b0 || b.pass !== (ms == g) || b.pat_out !== mp ||
        b.signature !== ms || b.pat_count !== n) begin
      errors++;
      $display("FAIL run_end: busy=%b done=%b pass=%b pat=%h sig=%h cnt=%0d exp pass=%b pat=%h sig=%h cnt=%0d",
               b.busy, b.done, b.pass, b.pat_out, b.signature, b.pat_count, (ms == g), mp, ms, n);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (b.pat_out !== 20'h0 || b.signature !== 12'h0 || b.pat_count !== '0 ||
        b.busy !== 1'b0 || b.done !== 1'b0 || b.pass !== 1'b0) begin
      errors++;
      $display("FAIL reset: pat=%h sig=%h cnt=%0d busy=%b done=%b pass=%b exp all 0",
               b.pat_out, b.signature, b.pat_count, b.busy, b.done, b.pass);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    b.start = 1'b1; b.seed = 20'h00001; b.num_patterns = CW'(1); b.resp_in = 12'h001;
    b.golden_sig = 12'h001;
    @(negedge clk);
    b.start = 1'b0;
    checks++;
    if (b.busy !== 1'b1 || b.done !== 1'b0 || b.pat_out !== 20'h00001) begin
      errors++;
      $display("FAIL single_apply: busy=%b done=%b pat=%h exp 1 0 00001", b.busy, b.done, b.pat_out);
    end
    @(negedge clk);
    checks++;
    if (b.busy !== 1'b1 || b.done !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: busy=%b done=%b exp 1 0", b.busy, b.done);
    end
    @(negedge clk);
    checks++;
    if (b.done !== 1'b1 || b.signature !== 12'h001 || b.pat_count !== CW'(1) || b.pat_out !== 20'h00002) begin
      errors++;
      $display("FAIL single_done: done=%b sig=%h cnt=%0d pat=%h exp 1 001 1 00002",
               b.done, b.signature, b.pat_count, b.pat_out);
    end
    @(negedge clk);
    checks++;
    if (b.busy !== 1'b0 || b.done !== 1'b0 || b.pass !== 1'b1) begin
      errors++;
      $display("FAIL single_pass: busy=%b done=%b pass=%b exp 0 0 1", b.busy, b.done, b.pass);
    end
  endtask

  task automatic test_misr_known;
    @(negedge clk);
    b.start = 1'b1; b.seed = 20'h12345; b.num_patterns = CW'(2); b.resp_in = 12'h800;
    b.golden_sig = 12'h853;
    @(negedge clk);
    b.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (b.signature !== 12'h800 || b.done !== 1'b0) begin
      errors++;
      $display("FAIL misr_first: sig=%h done=%b exp 800 0", b.signature, b.done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (b.signature !== 12'h853 || b.done !== 1'b1) begin
      errors++;
      $display("FAIL misr_second: sig=%h done=%b exp 853 1", b.signature, b.done);
    end
    @(negedge clk);
    checks++;
    if (b.pass !== 1'b1) begin
      errors++;
      $display("FAIL misr_pass: pass=%b exp 1", b.pass);
    end
  endtask

  task automatic test_lfsr_wrap;
    @(negedge clk);
    b.start = 1'b1; b.seed = 20'h80000; b.num_patterns = CW'(1);
    @(negedge clk);
    b.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (b.pat_out !== 20'h00001) begin
      errors++;
      $display("FAIL lfsr_wrap: pat=%h exp 00001", b.pat_out);
    end
    @(negedge clk);
    b.start = 1'b1; b.seed = 20'h0;
    @(negedge clk);
    b.start = 1'b0;
    checks++;
    if (b.pat_out !== 20'h00001) begin
      errors++;
      $display("FAIL seed_zero: pat=%h exp 00001", b.pat_out);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero_patterns;
    logic [11:0] gs [2];
    gs[0] = 12'h000;
    gs[1] = 12'h5A5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b.start = 1'b1; b.num_patterns = '0; b.golden_sig = gs[i]; b.seed = 20'($urandom);
      @(negedge clk);
      b.start = 1'b0;
      checks++;
      if (b.done !== 1'b1 || b.busy !== 1'b1 || b.signature !== 12'h0 || b.pat_count !== '0) begin
        errors++;
        $display("FAIL zero_done: done=%b busy=%b sig=%h cnt=%0d exp 1 1 000 0",
                 b.done, b.busy, b.signature, b.pat_count);
      end
      @(negedge clk);
      checks++;
      if (b.busy !== 1'b0 || b.done !== 1'b0 || b.pass !== (gs[i] == 12'h0)) begin
        errors++;
        $display("FAIL zero_pass: busy=%b done=%b pass=%b exp pass=%b",
                 b.busy, b.done, b.pass, (gs[i] == 12'h0));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] s1;
    logic [19:0] s2;
    s1 = 20'($urandom) | 20'h1;
    s2 = 20'($urandom) | 20'h2;
    @(negedge clk);
    b.start = 1'b1; b.seed = s1; b.num_patterns = CW'(1);
    @(negedge clk);
    b.seed = s2; b.num_patterns = CW'(2);
    repeat (2) @(negedge clk);
    checks++;
    if (b.done !== 1'b1 || b.pat_out !== lfsr_ref(s1)) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b pat=%h exp 1 %h", b.done, b.pat_out, lfsr_ref(s1));
    end
    @(negedge clk);
    checks++;
    if (b.busy !== 1'b0 || b.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b exp 0 0", b.busy, b.done);
    end
    @(negedge clk);
    b.start = 1'b0;
    checks++;
    if (b.busy !== 1'b1 || b.pat_out !== s2 || b.pat_count !== '0) begin
      errors++;
      $display("FAIL b2b_relaunch: busy=%b pat=%h cnt=%0d exp 1 %h 0", b.busy, b.pat_out, b.pat_count, s2);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (b.busy !== 1'b0 || b.pat_count !== CW'(2)) begin
      errors++;
      $display("FAIL b2b_second_end: busy=%b cnt=%0d exp 0 2", b.busy, b.pat_count);
    end
  endtask

  task automatic test_reset_abort;
    int seen_done;
    @(negedge clk);
    b.start = 1'b1; b.seed = 20'($urandom); b.num_patterns = CW'(3);
    @(negedge clk);
    b.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (b.pat_out !== 20'h0 || b.signature !== 12'h0 || b.pat_count !== '0 ||
        b.busy !== 1'b0 || b.done !== 1'b0 || b.pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: pat=%h sig=%h cnt=%0d busy=%b done=%b pass=%b exp all 0",
               b.pat_out, b.signature, b.pat_count, b.busy, b.done, b.pass);
    end
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b.done !== 1'b0) seen_done++;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL reset_no_done: done seen %0d times exp 0", seen_done);
    end
    run_model(20'($urandom), CW'(2), 1'b0);
  endtask

  task automatic test_random;
    logic [19:0] sd;
    for (int i = 0; i < 30; i++) begin
      sd = ($urandom_range(0, 7) == 0) ? 20'h0 : 20'($urandom);
      run_model(sd, CW'($urandom_range(0, 12)), 1'($urandom));
    end
  endtask

  task automatic test_max_count;
    run_model(20'($urandom), {CW{1'b1}}, 1'b0);
  endtask

  initial begin
    b.start = 1'b0; b.num_patterns = '0; b.seed = '0; b.golden_sig = '0; b.resp_in = '0;
    test_reset();
    test_single();
    test_misr_known();
    test_lfsr_wrap();
    test_zero_patterns();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_max_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
